pass_entry_ctrl: RTL and testbench

- Initiator side of the door-lock password handshake.
- Collects keypad entries (password code, then direction code) and drives req/confirm/pass_data into the lock FSM.
- Tracks the lock's state feedback, counts failed attempts and enforces a lockout period.
- Sits between the keypad scanner/debouncer and the lock FSM.

---
 rtl/lock_pkg.sv | 28 ++
 rtl/pass_entry_ctrl_if.sv | 38 +++
 rtl/cycle_timer.sv | 33 +++
 rtl/pass_entry_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_pass_entry_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lock_pkg.sv
// Shared door-lock definitions: lock state codes, controller states,
// password constant and default data width.
package lock_pkg;

  localparam int DATA_W_DEF = 4;

  localparam logic [3:0] PASSWORD = 4'b0101;

  localparam logic [2:0] L_IDLE = 3'b000;
  localparam logic [2:0] L_WAIT = 3'b001;
  localparam logic [2:0] L_OK   = 3'b101;
  localparam logic [2:0] L_FAIL = 3'b111;
  localparam logic [2:0] L_DONE = 3'b110;

  typedef logic [3:0] ctrl_state_t;

  localparam ctrl_state_t S_IDLE         = 4'd0;
  localparam ctrl_state_t S_COLLECT_PASS = 4'd1;
  localparam ctrl_state_t S_ARM          = 4'd2;
  localparam ctrl_state_t S_SEND_PASS    = 4'd3;
  localparam ctrl_state_t S_CHECK        = 4'd4;
  localparam ctrl_state_t S_COLLECT_DIR  = 4'd5;
  localparam ctrl_state_t S_SEND_DIR     = 4'd6;
  localparam ctrl_state_t S_WAIT_DONE    = 4'd7;
  localparam ctrl_state_t S_RELEASE      = 4'd8;
  localparam ctrl_state_t S_LOCKOUT      = 4'd9;

endpackage

// File: rtl/pass_entry_ctrl_if.sv
// Keypad inputs and lock handshake between the entry controller
// (master) and its keypad/lock environment (slave).
interface pass_entry_ctrl_if #(
  parameter int DATA_W = 4
);

  logic              key_valid;
  logic [DATA_W-1:0] key_code;
  logic              key_enter;
  logic              key_cancel;
  logic [2:0]        lock_state;
  logic              req;
  logic              confirm;
  logic [DATA_W-1:0] pass_data;

  modport master (
    input  key_valid,
    input  key_code,
    input  key_enter,
    input  key_cancel,
    input  lock_state,
    output req,
    output confirm,
    output pass_data
  );

  modport slave (
    output key_valid,
    output key_code,
    output key_enter,
    output key_cancel,
    output lock_state,
    input  req,
    input  confirm,
    input  pass_data
  );

endinterface

// File: rtl/cycle_timer.sv
// Down-counter: start loads a value, expired is high once it reaches 0.
module cycle_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/pass_entry_ctrl.sv
// Initiator side of the door-lock password handshake.
// Optional ENTRY_TIMEOUT_EN adds an inactivity timeout in COLLECT states.
module pass_entry_ctrl
  import lock_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int MAX_TRIES    = 3,
  parameter int LOCKOUT_CYC  = 16,
  parameter int RESP_TIMEOUT = 8
`ifdef ENTRY_TIMEOUT_EN
  ,
  parameter int IDLE_TIMEOUT = 64
`endif
) (
  input  logic                clk,
  input  logic                rst,
  pass_entry_ctrl_if.master   bus,
  output logic                busy,
  output logic                locked_out,
  output logic [1:0]          tries_left,
  output logic                grant,
  output logic                deny,
  output logic                err
);

  localparam int T_A = (LOCKOUT_CYC > RESP_TIMEOUT) ?
                       LOCKOUT_CYC : RESP_TIMEOUT;
`ifdef ENTRY_TIMEOUT_EN
  localparam int T_MAX = (IDLE_TIMEOUT > T_A) ? IDLE_TIMEOUT : T_A;
`else
  localparam int T_MAX = T_A;
`endif
  localparam int CNT_W = $clog2(T_MAX + 1);

  localparam logic [CNT_W-1:0] RESP_LD = CNT_W'(RESP_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LOCK_LD = CNT_W'(LOCKOUT_CYC - 1);
  localparam logic [1:0]       TRIES0  = 2'(MAX_TRIES);

  ctrl_state_t       state_q, state_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic [DATA_W-1:0] pd_q, pd_d;
  logic              dir_seen_q, dir_seen_d;
  logic [1:0]        tries_q, tries_d;
  logic              grant_q, grant_d;
  logic              deny_q, deny_d;
  logic              err_q, err_d;

  logic              tmr_start;
  logic [CNT_W-1:0]  tmr_load;
  logic              tmr_exp;

`ifdef ENTRY_TIMEOUT_EN
  localparam logic [CNT_W-1:0] IDLE_LD = CNT_W'(IDLE_TIMEOUT - 1);
  logic strobe;
  assign strobe = bus.key_valid | bus.key_enter | bus.key_cancel;
`endif

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    pd_d       = pd_q;
    dir_seen_d = dir_seen_q;
    tries_d    = tries_q;
    grant_d    = 1'b0;
    deny_d     = 1'b0;
    err_d      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.key_valid) begin
          buf_d   = bus.key_code;
          state_d = S_COLLECT_PASS;
        end
      end
      S_COLLECT_PASS: begin
        if (bus.key_valid) buf_d = bus.key_code;
        if (bus.key_cancel) state_d = S_IDLE;
        else if (bus.key_enter) state_d = S_ARM;
`ifdef ENTRY_TIMEOUT_EN
        else if (tmr_exp && !strobe) state_d = S_IDLE;
`endif
      end
      S_ARM: begin
        if (bus.lock_state == L_WAIT) begin
          pd_d    = buf_q;
          state_d = S_SEND_PASS;
        end else if (tmr_exp) begin
          err_d   = 1'b1;
          state_d = S_RELEASE;
        end
      end
      S_SEND_PASS: state_d = S_CHECK;
      S_CHECK: begin
        if (bus.lock_state == L_OK) begin
          tries_d    = TRIES0;
          buf_d      = '0;
          dir_seen_d = 1'b0;
          state_d    = S_COLLECT_DIR;
        end else if (bus.lock_state == L_FAIL) begin
          deny_d  = 1'b1;
          tries_d = tries_q - 2'd1;
          state_d = (tries_q == 2'd1) ? S_LOCKOUT : S_RELEASE;
        end else if (tmr_exp) begin
          err_d   = 1'b1;
          state_d = S_RELEASE;
        end
      end
      S_COLLECT_DIR: begin
        if (bus.key_valid) begin
          buf_d      = bus.key_code;
          dir_seen_d = 1'b1;
        end
        if (bus.key_cancel) state_d = S_RELEASE;
        else if (bus.key_enter && (dir_seen_q || bus.key_valid)) begin
          pd_d    = buf_d;
          state_d = S_SEND_DIR;
        end
`ifdef ENTRY_TIMEOUT_EN
        else if (tmr_exp && !strobe) state_d = S_RELEASE;
`endif
      end
      S_SEND_DIR: state_d = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (bus.lock_state == L_DONE) begin
          grant_d = 1'b1;
          state_d = S_RELEASE;
        end else if (tmr_exp) begin
          err_d   = 1'b1;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: state_d = S_IDLE;
      S_LOCKOUT: begin
        if (tmr_exp) begin
          tries_d = TRIES0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_IDLE) buf_d = '0;
  end

  // One timer serves every timed state; it reloads on each state change.
  always_comb begin
    tmr_start = (state_d != state_q);
`ifdef ENTRY_TIMEOUT_EN
    if (strobe && (state_q == S_COLLECT_PASS ||
                   state_q == S_COLLECT_DIR)) begin
      tmr_start = 1'b1;
    end
`endif
    tmr_load = '0;
    unique case (1'b1)
      (state_d == S_ARM),
      (state_d == S_CHECK),
      (state_d == S_WAIT_DONE): tmr_load = RESP_LD;
      (state_d == S_LOCKOUT):   tmr_load = LOCK_LD;
`ifdef ENTRY_TIMEOUT_EN
      (state_d == S_COLLECT_PASS),
      (state_d == S_COLLECT_DIR): tmr_load = IDLE_LD;
`endif
      default: tmr_load = '0;
    endcase
  end

  cycle_timer #(
    .W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst),
    .start    (tmr_start),
    .load_val (tmr_load),
    .expired  (tmr_exp)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      buf_q      <= '0;
      pd_q       <= '0;
      dir_seen_q <= 1'b0;
      tries_q    <= TRIES0;
      grant_q    <= 1'b0;
      deny_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      pd_q       <= pd_d;
      dir_seen_q <= dir_seen_d;
      tries_q    <= tries_d;
      grant_q    <= grant_d;
      deny_q     <= deny_d;
      err_q      <= err_d;
    end
  end

  assign bus.req = (state_q == S_ARM) || (state_q == S_SEND_PASS) ||
                   (state_q == S_CHECK) || (state_q == S_COLLECT_DIR) ||
                   (state_q == S_SEND_DIR) || (state_q == S_WAIT_DONE);
  assign bus.confirm   = (state_q == S_SEND_PASS) ||
                         (state_q == S_SEND_DIR);
  assign bus.pass_data = pd_q;
  assign busy          = (state_q != S_IDLE);
  assign locked_out    = (state_q == S_LOCKOUT);
  assign tries_left    = tries_q;
  assign grant         = grant_q;
  assign deny          = deny_q;
  assign err           = err_q;

endmodule

// File: tb/tb_pass_entry_ctrl.sv
// Session-level bench for pass_entry_ctrl with a behavioural lock model,
// a directed vector table, hand sequences and random sessions.
module tb_pass_entry_ctrl;
  import lock_pkg::*;

  localparam int DW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pass_entry_ctrl_if #(.DATA_W(DW)) bus ();

  logic       busy, locked_out, grant, deny, err;
  logic [1:0] tries_left;

  pass_entry_ctrl #(
    .DATA_W       (DW),
    .MAX_TRIES    (3),
    .LOCKOUT_CYC  (16),
    .RESP_TIMEOUT (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .busy       (busy),
    .locked_out (locked_out),
    .tries_left (tries_left),
    .grant      (grant),
    .deny       (deny),
    .err        (err)
  );

  // Behavioural lock: waits for req, judges the password, then the direction.
  logic [2:0] lk_st;
  bit         lk_mute;
  always @(posedge clk or negedge rst) begin
    if (!rst) lk_st <= L_IDLE;
    else if (!bus.req || lk_mute) lk_st <= L_IDLE;
    else begin
      case (lk_st)
        L_IDLE: lk_st <= L_WAIT;
        L_WAIT: if (bus.confirm)
                  lk_st <= (bus.pass_data == PASSWORD) ? L_OK : L_FAIL;
        L_OK:   if (bus.confirm) lk_st <= L_DONE;
        default: ;
      endcase
    end
  end
  assign bus.lock_state = lk_st;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int m_grant, m_deny, m_err, m_err_cyc, m_lo, m_req_lo, m_rel;
  int req_run;
  bit m_req_seen;
  logic [3:0] m_conf[$];

  always @(negedge clk) begin
    if (rst) begin
      if (bus.req) req_run++;
      else req_run = 0;
      if (grant) m_grant++;
      if (deny) m_deny++;
      if (err) begin
        m_err++;
        m_err_cyc = cyc;
      end
      if (locked_out) m_lo++;
      if (locked_out && bus.req) m_req_lo++;
      if (bus.req) m_req_seen = 1;
      if (busy && !bus.req && m_req_seen && !locked_out) m_rel++;
      if (bus.confirm) begin
        m_conf.push_back(bus.pass_data);
        chk("confirm_after_req", (req_run >= 3), 1);
      end
    end else begin
      req_run = 0;
    end
  end

  typedef struct {
    logic [3:0] pw;
    logic [3:0] dir;
    bit mute;
    bit cpass;
    bit cdir;
    int e_grant;
    int e_deny;
    int e_err;
    int e_tries;
    int e_lo;
    int e_rel;
    int e_nconf;
  } vec_t;

  function automatic vec_t mk(
    input logic [3:0] pw, input logic [3:0] dir,
    input bit mute, input bit cpass, input bit cdir,
    input int g, input int d, input int e, input int t,
    input int lo, input int rel, input int nc);
    vec_t v;
    v.pw = pw; v.dir = dir; v.mute = mute;
    v.cpass = cpass; v.cdir = cdir;
    v.e_grant = g; v.e_deny = d; v.e_err = e; v.e_tries = t;
    v.e_lo = lo; v.e_rel = rel; v.e_nconf = nc;
    return v;
  endfunction

  // Session outcome from the rules alone, given attempts left beforehand.
  function automatic vec_t model(input vec_t v, input int tries_in);
    vec_t r = mk(v.pw, v.dir, v.mute, v.cpass, v.cdir,
                 0, 0, 0, tries_in, 0, 0, 0);
    if (v.cpass) begin
    end else if (v.mute) begin
      r.e_err = 1;
      r.e_rel = 1;
    end else if (v.pw == PASSWORD) begin
      r.e_tries = 3;
      r.e_grant = v.cdir ? 0 : 1;
      r.e_nconf = v.cdir ? 1 : 2;
      r.e_rel = 1;
    end else begin
      r.e_deny = 1;
      r.e_nconf = 1;
      if (tries_in == 1) begin
        r.e_lo = 16;
        r.e_tries = 3;
      end else begin
        r.e_tries = tries_in - 1;
        r.e_rel = 1;
      end
    end
    return r;
  endfunction

  task automatic run_session(input vec_t v, input string tag);
    int t_enter;
    bit reached_ok;
    bit done;
    m_grant = 0; m_deny = 0; m_err = 0; m_err_cyc = 0;
    m_lo = 0; m_req_lo = 0; m_rel = 0; m_req_seen = 0;
    m_conf.delete();
    lk_mute = v.mute;
    bus.key_valid = 1'b1;
    bus.key_code = v.pw;
    tick();
    bus.key_valid = 1'b0;
    tick();
    bus.key_enter = 1'b1;
    bus.key_cancel = v.cpass;
    t_enter = cyc;
    tick();
    bus.key_enter = 1'b0;
    bus.key_cancel = 1'b0;
    reached_ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (lk_st == L_OK) begin
        reached_ok = 1;
        break;
      end
      if (!busy || locked_out) break;
      tick();
    end
    if (reached_ok) begin
      tick();
      if (v.cdir) begin
        bus.key_cancel = 1'b1;
        tick();
        bus.key_cancel = 1'b0;
      end else begin
        bus.key_valid = 1'b1;
        bus.key_code = v.dir;
        tick();
        bus.key_valid = 1'b0;
        bus.key_enter = 1'b1;
        tick();
        bus.key_enter = 1'b0;
      end
    end
    done = 0;
    for (int i = 0; i < 80; i++) begin
      if (!busy) begin
        done = 1;
        break;
      end
      bus.key_valid = locked_out;
      bus.key_enter = locked_out;
      bus.key_code = PASSWORD;
      tick();
    end
    bus.key_valid = 1'b0;
    bus.key_enter = 1'b0;
    chk({tag, ".end"}, done, 1);
    chk({tag, ".grant"}, m_grant, v.e_grant);
    chk({tag, ".deny"}, m_deny, v.e_deny);
    chk({tag, ".err"}, m_err, v.e_err);
    chk({tag, ".tries"}, tries_left, v.e_tries);
    chk({tag, ".lockout"}, m_lo, v.e_lo);
    chk({tag, ".req_in_lockout"}, m_req_lo, 0);
    chk({tag, ".release"}, m_rel, v.e_rel);
    chk({tag, ".nconf"}, m_conf.size(), v.e_nconf);
    for (int k = 0; k < m_conf.size() && k < v.e_nconf; k++)
      chk($sformatf("%s.conf%0d", tag, k), m_conf[k],
          (k == 0) ? v.pw : v.dir);
    if (v.e_err == 1)
      chk({tag, ".err_delay"}, m_err_cyc - t_enter, 9);
    tick();
    tick();
  endtask

  vec_t tbl[12];
  int tries_m;
  bit seen;

  initial begin
    tbl[0]  = mk(4'b0101, 4'b0100, 0, 0, 0, 1, 0, 0, 3, 0, 1, 2);
    tbl[1]  = mk(4'b0011, 4'b0000, 0, 0, 0, 0, 1, 0, 2, 0, 1, 1);
    tbl[2]  = mk(4'b0101, 4'b1001, 0, 0, 0, 1, 0, 0, 3, 0, 1, 2);
    tbl[3]  = mk(4'b0000, 4'b0000, 0, 0, 0, 0, 1, 0, 2, 0, 1, 1);
    tbl[4]  = mk(4'b0001, 4'b0000, 0, 0, 0, 0, 1, 0, 1, 0, 1, 1);
    tbl[5]  = mk(4'b0010, 4'b0000, 0, 0, 0, 0, 1, 0, 3, 16, 0, 1);
    tbl[6]  = mk(4'b0101, 4'b0000, 1, 0, 0, 0, 0, 1, 3, 0, 1, 0);
    tbl[7]  = mk(4'b0111, 4'b0000, 0, 0, 0, 0, 1, 0, 2, 0, 1, 1);
    tbl[8]  = mk(4'b0000, 4'b0000, 1, 0, 0, 0, 0, 1, 2, 0, 1, 0);
    tbl[9]  = mk(4'b0101, 4'b0000, 0, 1, 0, 0, 0, 0, 2, 0, 0, 0);
    tbl[10] = mk(4'b0101, 4'b0011, 0, 0, 1, 0, 0, 0, 3, 0, 1, 1);
    tbl[11] = mk(4'b1111, 4'b0000, 0, 0, 0, 0, 1, 0, 2, 0, 1, 1);

    rst = 1'b0;
    lk_mute = 0;
    bus.key_valid = 1'b0;
    bus.key_code = '0;
    bus.key_enter = 1'b0;
    bus.key_cancel = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();

    chk("rst.req", bus.req, 0);
    chk("rst.confirm", bus.confirm, 0);
    chk("rst.pass_data", bus.pass_data, 0);
    chk("rst.busy", busy, 0);
    chk("rst.locked_out", locked_out, 0);
    chk("rst.tries", tries_left, 3);
    chk("rst.pulses", {grant, deny, err}, 0);

    bus.key_enter = 1'b1;
    tick();
    bus.key_enter = 1'b0;
    tick();
    chk("idle_enter.busy", busy, 0);
    chk("idle_enter.req", bus.req, 0);

    for (int i = 0; i < 12; i++)
      run_session(tbl[i], $sformatf("vec%0d", i));

    chk("pass_data_hold", bus.pass_data, 4'b1111);

    // Reset while SEND_PASS drives confirm.
    lk_mute = 0;
    bus.key_valid = 1'b1;
    bus.key_code = PASSWORD;
    tick();
    bus.key_valid = 1'b0;
    bus.key_enter = 1'b1;
    tick();
    bus.key_enter = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.confirm) begin
        seen = 1;
        break;
      end
      tick();
    end
    chk("rst_mid.confirm_seen", seen, 1);
    chk("rst_mid.tries_before", tries_left, 2);
    rst = 1'b0;
    #1;
    chk("rst_mid.confirm", bus.confirm, 0);
    chk("rst_mid.req", bus.req, 0);
    chk("rst_mid.pass_data", bus.pass_data, 0);
    chk("rst_mid.tries", tries_left, 3);
    chk("rst_mid.busy", busy, 0);
    tick(); tick();
    rst = 1'b1;
    tick();

    tries_m = 3;
    for (int i = 0; i < 24; i++) begin
      vec_t v;
      vec_t r;
      v.pw = ($urandom_range(0, 1) == 1) ? PASSWORD : 4'($urandom);
      v.dir = 4'($urandom);
      v.mute = ($urandom_range(0, 5) == 0);
      v.cpass = ($urandom_range(0, 7) == 0);
      v.cdir = ($urandom_range(0, 3) == 0);
      r = model(v, tries_m);
      tries_m = r.e_tries;
      run_session(r, $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
